// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p: in-order pipeline hazard controller (bypass selects, stalls, flush).
// Optional perf counters (stall_cnt/flush_cnt/ldhaz_cnt) under `define HAZARD_PERF_EN.
module hazard_ctrl_p #(
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 2,
   parameter int SEL_W     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              is_j,
   input  logic              is_b,
   input  logic              is_load,
   input  logic              is_md,
   input  logic              dst_en,
   input  logic [REG_AW-1:0] r_dst,
   input  logic [REG_AW-1:0] r_src1,
   input  logic [REG_AW-1:0] r_src2,
   input  logic              pre_taken,
   input  logic              real_taken,
   input  logic              md_fin,
   input  logic              f_cmiss,
   input  logic              f_arrival,
   input  logic              m_cmiss,
   input  logic              m_arrival,
   output logic [SEL_W-1:0]  src1_sel,
   output logic [SEL_W-1:0]  src2_sel,
   output logic              fd_st,
   output logic              de_st,
   output logic              em_st,
   output logic              flush,
   output logic              ptnt
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt,
   output logic [31:0]       ldhaz_cnt
`endif
);
   typedef enum logic {IDLE, BUSY} md_state_e;
   md_state_e md_state_q, md_state_d;
   logic [FWD_DEPTH-1:0]             vld_q, vld_d, ld_q, ld_d;
   logic [FWD_DEPTH-1:0][REG_AW-1:0] addr_q, addr_d;
   logic ic_keep_q, ic_keep_d, dc_keep_q, dc_keep_d;
   logic jpend_q, jpend_d, bpend_q, bpend_d, bpred_q, bpred_d;
   logic ic_st, dc_st, md_st, ldhaz, capture, bubble;
   // Scan oldest to youngest so the youngest matching entry overrides.
   always_comb begin
      src1_sel = '0;
      src2_sel = '0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (vld_q[k] && addr_q[k] == r_src1 && r_src1 != '0) src1_sel = SEL_W'(k + 1);
         if (vld_q[k] && addr_q[k] == r_src2 && r_src2 != '0) src2_sel = SEL_W'(k + 1);
      end
   end
   assign ldhaz   = vld_q[0] & ld_q[0] & ((addr_q[0] == r_src1 && r_src1 != '0) |
                                          (addr_q[0] == r_src2 && r_src2 != '0));
   assign ic_st   = ~f_arrival & (f_cmiss | ic_keep_q);
   assign dc_st   = ~m_arrival & (m_cmiss | dc_keep_q);
   assign md_st   = (md_state_q == IDLE) ? (is_md & ~flush) : ~md_fin;
   assign fd_st   = md_st | ic_st | dc_st | ldhaz;
   assign de_st   = ldhaz | dc_st;
   assign em_st   = dc_st;
   assign flush   = jpend_q | (bpend_q & (bpred_q ^ real_taken));
   assign ptnt    = bpend_q & bpred_q & ~real_taken;
   assign capture = ~flush & ~de_st;
   assign bubble  = de_st | flush;
   always_comb begin
      ic_keep_d  = f_cmiss | (ic_keep_q & ~f_arrival);
      dc_keep_d  = m_cmiss | (dc_keep_q & ~m_arrival);
      md_state_d = (md_state_q == IDLE) ? ((is_md & capture) ? BUSY : IDLE) : (md_fin ? IDLE : BUSY);
      jpend_d    = em_st ? jpend_q : capture & is_j;
      bpend_d    = em_st ? bpend_q : capture & ~is_j & is_b;
      bpred_d    = em_st ? bpred_q : capture & ~is_j & is_b & pre_taken;
      vld_d      = vld_q;
      ld_d       = ld_q;
      addr_d     = addr_q;
      if (!em_st) begin
         for (int k = 1; k < FWD_DEPTH; k++) begin
            vld_d[k]  = vld_q[k-1];
            ld_d[k]   = ld_q[k-1];
            addr_d[k] = addr_q[k-1];
         end
         vld_d[0]  = ~bubble & dst_en & (r_dst != '0);
         ld_d[0]   = ~bubble & is_load;
         addr_d[0] = bubble ? '0 : r_dst;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         md_state_q <= IDLE;
         vld_q      <= '0;
         ld_q       <= '0;
         addr_q     <= '0;
         ic_keep_q  <= 1'b0;
         dc_keep_q  <= 1'b0;
         jpend_q    <= 1'b0;
         bpend_q    <= 1'b0;
         bpred_q    <= 1'b0;
      end else begin
         md_state_q <= md_state_d;
         vld_q      <= vld_d;
         ld_q       <= ld_d;
         addr_q     <= addr_d;
         ic_keep_q  <= ic_keep_d;
         dc_keep_q  <= dc_keep_d;
         jpend_q    <= jpend_d;
         bpend_q    <= bpend_d;
         bpred_q    <= bpred_d;
      end
   end
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, ldhaz_cnt_q, ldhaz_cnt_d;
   always_comb begin
      stall_cnt_d = stall_cnt_q + 32'(fd_st);
      flush_cnt_d = flush_cnt_q + 32'(flush);
      ldhaz_cnt_d = ldhaz_cnt_q + 32'(ldhaz);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         ldhaz_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         ldhaz_cnt_q <= ldhaz_cnt_d;
      end
   end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign ldhaz_cnt = ldhaz_cnt_q;
`endif
endmodule

// File: doc/hazard_ctrl_p.md
Name: hazard_ctrl_p

Overview:
- Parametrised pipeline hazard controller for the in-order RV core; sits beside decode/execute.
- Tracks in-flight destination registers across a configurable number of forwarding stages and produces per-source bypass selects.
- Generates fetch/decode/execute stalls for load-use, I/D-cache miss and multi-cycle mul/div.
- Generates a single-cycle flush on jump redirect or branch misprediction.

Parameters:
REG_AW, 5, register address width (2**REG_AW architectural registers; x0 never forwarded).
FWD_DEPTH, 2, number of tracked in-flight stages (1..4); entry 0 is youngest (E), entry FWD_DEPTH-1 oldest.
SEL_W, 2, width of the bypass select; must be >= clog2(FWD_DEPTH+1).

Ports:
clk  in  1  core clock.
rst  in  1  asynchronous reset, active-high.
is_j  in  1  decode holds jal/jalr.
is_b  in  1  decode holds conditional branch.
is_load  in  1  decode holds load.
is_md  in  1  decode holds mul/div.
dst_en  in  1  decode instruction writes r_dst.
r_dst  in  REG_AW  decode destination register.
r_src1  in  REG_AW  decode source 1.
r_src2  in  REG_AW  decode source 2.
pre_taken  in  1  branch predictor decision for decode branch.
real_taken  in  1  execute branch outcome, valid in the cycle after branch leaves decode.
md_fin  in  1  mul/div unit done pulse.
f_cmiss  in  1  I-cache miss pulse.
f_arrival  in  1  I-cache refill done pulse.
m_cmiss  in  1  D-cache miss pulse.
m_arrival  in  1  D-cache refill done pulse.
src1_sel  out  SEL_W  0 = register file, k = forward from entry k-1.
src2_sel  out  SEL_W  as src1_sel.
fd_st  out  1  hold F/D register.
de_st  out  1  hold D/E register (bubble inserted into E).
em_st  out  1  hold E/M and downstream.
flush  out  1  kill F and D contents this cycle.
ptnt  out  1  predicted taken, actually not taken (fetch redirects to fall-through).

Behaviour:
- Reset (async, rst=1): all tracking entries invalid, all keep flags 0, FSMs IDLE; outputs src*_sel=0, all stalls 0, flush=0, ptnt=0.
- Tracking pipe: entry = {vld, addr, ld}. When em_st=0: entries shift 0->1->...; entry0 <= bubble if (de_st|flush), else {dst_en & (r_dst!=0), r_dst, is_load}. When em_st=1: all entries hold.
- Bypass: srcN_sel = k for the lowest index k-1 with vld & addr==r_srcN; 0 if r_srcN==0 or no match. Youngest wins on multiple matches. Combinational.
- Load-use: ldhaz = entry0.vld & entry0.ld & (match src1 | match src2), nonzero sources only. Asserts exactly 1 cycle per dependent load (bubble clears entry0 next cycle).
- Miss keeps: ic_keep set on f_cmiss, cleared on f_arrival (set wins if both). ic_st = ~f_arrival & (f_cmiss | ic_keep). dc_keep/dc_st identical with m_*.
- MD FSM: IDLE -> BUSY when is_md & ~flush & ~de_st; BUSY -> IDLE on md_fin. md_st = (IDLE & is_md & ~flush) | (BUSY & ~md_fin). md_fin in IDLE is ignored.
- fd_st = md_st | ic_st | dc_st | ldhaz; de_st = ldhaz | dc_st; em_st = dc_st.
- Control FSM registers: jpend, bpend, bpred.
  - Capture when ~flush & ~de_st: is_j sets jpend; else is_b sets bpend, bpred=pre_taken. Otherwise cleared (unless em_st=1, which holds them).
- flush = jpend | (bpend & (bpred ^ real_taken)); ptnt = bpend & bpred & ~real_taken. Each is a single cycle per instruction.
- Instructions in decode while flush=1 are never captured (no back-to-back flush).
- rst mid-miss or mid-mul/div: all keeps and FSMs return to IDLE immediately; a later stray arrival/fin is ignored.

Optional Feature:
HAZARD_PERF_EN: adds 32-bit outputs stall_cnt (cycles with fd_st=1), flush_cnt (flush pulses) and ldhaz_cnt. All wrap at 2**32 and clear on rst. Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- addi x5 then add x6,x5,x5 (FWD_DEPTH=2) -> next decode src1_sel=src2_sel=1; two cycles later a reader of x5 sees sel=2; a reader of x0 always sees sel 0.
- lw x7 then add x8,x7,x1 -> ldhaz, fd_st=de_st=1 for exactly 1 cycle, then src1_sel=2, src2_sel=0.
- f_cmiss at cycle 10, f_arrival at cycle 15 -> fd_st=1 in cycles 10-14, 0 at 15; de_st stays 0.
- Branch with pre_taken=1, real_taken=0 -> flush=1 and ptnt=1 for one cycle; pre_taken=0, real_taken=1 -> flush=1, ptnt=0; correct predictions -> no flush.
- Jump immediately followed by another jump in decode -> single flush pulse; second jump is not captured.
- mul issued, md_fin after 8 cycles, rst pulsed mid-way in a second run -> fd_st high until md_fin; after rst all outputs 0 and a late md_fin has no effect.
